app_desc_arbiter: RTL and testbench
===================================

APP_DESC_ARBITER -- requirements
Module: app_desc_arbiter

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- DESC_WIDTH, `RL_DESC_WIDTH: packet descriptor width.
- APP_ID_WIDTH, `RL_DESC_APP_ID_SIZE: application ID width; N_APP = 2**APP_ID_WIDTH.
- CNT_WIDTH, 8: per-app pending-counter width.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning), with clock and reset first:
- clk, in, 1: the single clock.
- rst_n, in, 1: reset, asynchronous and active-low.
- s_evt_valid, in, 1: arrival event for an app.
- s_evt_app_id, in, APP_ID_WIDTH: app of the arrival event.
- s_evt_ready, out, 1: tied to 1.
- s_app_mask, in, N_APP: per-app eligibility; 1 = may be scheduled.
- qm_packet_desc_req, out, 1: one-cycle fetch request to the queue manager.
- qm_packet_desc_app_id, out, APP_ID_WIDTH: app being fetched.
- qm_packet_desc, in, DESC_WIDTH: descriptor returned by the queue manager.
- qm_packet_desc_valid, in, 1: returned descriptor valid, single-cycle pulse.
- m_packet_desc, out, DESC_WIDTH: scheduled descriptor.
- m_packet_desc_valid, out, 1: scheduled descriptor valid.
- m_packet_desc_ready, in, 1: downstream ready.
- cnt_overflow, out, 1: sticky flag, set on an event dropped at a saturated counter.

Function
REQ-003 The block SHALL keep one CNT_WIDTH pending counter per app.
- Accepted event: increment the counter of s_evt_app_id.
- Issued REQ: decrement the counter of the granted app.

REQ-004 A counter at all-ones SHALL NOT increment; the event is dropped and cnt_overflow is set until reset.

REQ-005 An increment and a decrement on the same app in the same cycle SHALL leave that counter unchanged.

REQ-006 App k SHALL be eligible when its counter is nonzero and s_app_mask[k]=1.

REQ-007 Arbitration SHALL be round-robin.
- The search starts at rr_ptr and wraps modulo N_APP.
- After a grant to app k, rr_ptr = (k+1) mod N_APP; wrap from N_APP-1 goes to 0.

REQ-008 The FSM SHALL have the states IDLE, REQ, WAIT and OUT.

REQ-009 IDLE: if any app is eligible, the FSM SHALL register the grant into qm_packet_desc_app_id and go to REQ; otherwise it stays in IDLE.

REQ-010 REQ: qm_packet_desc_req SHALL be 1 for exactly this one cycle, the counter decrement occurs, and the FSM goes to WAIT.

REQ-011 WAIT: on qm_packet_desc_valid=1 the FSM SHALL capture qm_packet_desc into m_packet_desc and go to OUT; otherwise it stays in WAIT indefinitely.

REQ-012 OUT: m_packet_desc_valid SHALL be 1 with m_packet_desc held stable. When m_packet_desc_ready=1, m_packet_desc_valid drops the next cycle and the FSM returns to IDLE.

REQ-013 qm_packet_desc_valid arriving outside WAIT SHALL be ignored.

REQ-014 Mask changes SHALL affect only the next IDLE decision. Clearing the granted app's mask bit while in REQ, WAIT or OUT SHALL NOT abort the transaction.

REQ-015 Latency SHALL be as follows:
- Eligibility in IDLE at cycle t gives qm_packet_desc_req at t+1.
- qm_packet_desc_valid at cycle u gives m_packet_desc_valid at u+1.
- Maximum throughput is one descriptor per 4 cycles.

REQ-016 Events SHALL be accepted in every state, including the cycle of a grant.

REQ-017 qm_packet_desc_app_id SHALL hold its value from REQ through OUT.

Reset
REQ-018 Assertion of rst_n=0 SHALL asynchronously force the following, regardless of state:
- state IDLE;
- all counters 0 and rr_ptr 0;
- qm_packet_desc_req 0 and qm_packet_desc_app_id 0;
- m_packet_desc 0 and m_packet_desc_valid 0;
- cnt_overflow 0.

REQ-019 A reset asserted mid-transaction SHALL discard the in-flight descriptor.

REQ-020 After deassertion, the first grant SHALL be possible on the first clock edge that sees an eligible app.

Verification
REQ-021 Single event: app 2 event, mask=4'hF, returned desc 0xABCD two cycles after req.
- Required: req with app_id=2 one cycle after the counter becomes 1, then m_packet_desc_valid with 0xABCD.
- Counter 2 ends at 0.

REQ-022 Round-robin: 3 events each for apps 0, 1 and 3, ready held 1.
- Required grant order: 0,1,3,0,1,3,0,1,3.

REQ-023 Mask: app 1 has 2 events and mask=4'b1101.
- Required: no req while masked.
- Setting mask bit 1 gives a req with app_id=1 on the next IDLE cycle.

REQ-024 Saturation (CNT_WIDTH=8): 256 events to app 0 with mask=0.
- Required: counter stays at 255 and cnt_overflow=1.
- Then 255 grants occur after unmasking.

REQ-025 Backpressure and reset: hold m_packet_desc_ready=0 in OUT for 10 cycles.
- Required: valid held and desc stable; no new req issued.
- Asserting rst_n=0 in WAIT clears all outputs immediately.

Source files
------------

// File: rtl/app_desc_arbiter.sv
// Round-robin descriptor scheduler: per-app pending counters feed a 4-state
// fetch FSM that pulls one descriptor at a time from the queue manager.
`ifndef RL_DESC_WIDTH
`define RL_DESC_WIDTH 64
`endif
`ifndef RL_DESC_APP_ID_SIZE
`define RL_DESC_APP_ID_SIZE 2
`endif

module app_desc_cnt #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  input  logic                 dec,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 drop
);
  logic full;

  assign full = &cnt;
  // A simultaneous inc/dec nets to zero, so only a lone inc at full is dropped.
  assign drop = inc & ~dec & full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   cnt <= '0;
    else if (inc & ~dec & ~full)  cnt <= cnt + CNT_WIDTH'(1);
    else if (dec & ~inc)          cnt <= cnt - CNT_WIDTH'(1);
  end
endmodule

module app_desc_arbiter #(
  parameter int DESC_WIDTH   = `RL_DESC_WIDTH,
  parameter int APP_ID_WIDTH = `RL_DESC_APP_ID_SIZE,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s_evt_valid,
  input  logic [APP_ID_WIDTH-1:0]      s_evt_app_id,
  output logic                         s_evt_ready,
  input  logic [2**APP_ID_WIDTH-1:0]   s_app_mask,
  output logic                         qm_packet_desc_req,
  output logic [APP_ID_WIDTH-1:0]      qm_packet_desc_app_id,
  input  logic [DESC_WIDTH-1:0]        qm_packet_desc,
  input  logic                         qm_packet_desc_valid,
  output logic [DESC_WIDTH-1:0]        m_packet_desc,
  output logic                         m_packet_desc_valid,
  input  logic                         m_packet_desc_ready,
  output logic                         cnt_overflow
);
  localparam int N_APP = 2**APP_ID_WIDTH;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;

  state_t                             state, next;
  logic [N_APP-1:0][CNT_WIDTH-1:0]    cnt;
  logic [N_APP-1:0]                   inc, dec, drop, elig;
  logic [APP_ID_WIDTH-1:0]            rr_ptr, grant_id, idx;
  logic                               grant_found;

  assign s_evt_ready = 1'b1;

  for (genvar k = 0; k < N_APP; k++) begin : g_app
    assign inc[k]  = s_evt_valid && (s_evt_app_id == APP_ID_WIDTH'(k));
    assign dec[k]  = (state == REQ) && (qm_packet_desc_app_id == APP_ID_WIDTH'(k));
    assign elig[k] = (|cnt[k]) && s_app_mask[k];
    app_desc_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .inc  (inc[k]),
      .dec  (dec[k]),
      .cnt  (cnt[k]),
      .drop (drop[k])
    );
  end

  // First eligible app at or after rr_ptr, wrapping through the power-of-two range.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = '0;
    for (int i = 0; i < N_APP; i++) begin
      idx = rr_ptr + APP_ID_WIDTH'(i);
      if (!grant_found && elig[idx]) begin
        grant_found = 1'b1;
        grant_id    = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:    if (grant_found) next = REQ;
      REQ:     next = WAIT;
      WAIT:    if (qm_packet_desc_valid) next = OUT;
      OUT:     if (m_packet_desc_ready) next = IDLE;
      default: next = IDLE;
    endcase
  end

  assign qm_packet_desc_req  = (state == REQ);
  assign m_packet_desc_valid = (state == OUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qm_packet_desc_app_id <= '0;
      rr_ptr                <= '0;
      m_packet_desc         <= '0;
      cnt_overflow          <= 1'b0;
    end else begin
      if (state == IDLE && grant_found) begin
        qm_packet_desc_app_id <= grant_id;
        rr_ptr                <= grant_id + APP_ID_WIDTH'(1);
      end
      if (state == WAIT && qm_packet_desc_valid) m_packet_desc <= qm_packet_desc;
      if (|drop) cnt_overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_app_desc_arbiter.sv
// Bench for app_desc_arbiter: scenario tasks plus a transaction-level reference
// model that predicts grants, descriptors and overflow every cycle.
module tb_app_desc_arbiter;
  localparam int DW = 16, AW = 2, CW = 8, NA = 4, CMAX = 255;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          s_evt_valid = 1'b0;
  logic [AW-1:0] s_evt_app_id = '0;
  logic          s_evt_ready;
  logic [NA-1:0] s_app_mask = '0;
  logic          qm_req;
  logic [AW-1:0] qm_app_id;
  logic [DW-1:0] qm_desc = '0;
  logic          qm_valid = 1'b0;
  logic [DW-1:0] m_desc;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic          ovf;

  int            n_tests = 0, n_fail = 0;
  int            rdy_mode = 1;
  bit            resp_en = 1'b1, resp_fix = 1'b0;
  logic [DW-1:0] fix_desc = '0, stray_desc = '0;
  int            stray_seq = 0;
  int            grant_log[$];

  app_desc_arbiter #(.DESC_WIDTH(DW), .APP_ID_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_evt_valid(s_evt_valid), .s_evt_app_id(s_evt_app_id), .s_evt_ready(s_evt_ready),
    .s_app_mask(s_app_mask),
    .qm_packet_desc_req(qm_req), .qm_packet_desc_app_id(qm_app_id),
    .qm_packet_desc(qm_desc), .qm_packet_desc_valid(qm_valid),
    .m_packet_desc(m_desc), .m_packet_desc_valid(m_valid), .m_packet_desc_ready(m_ready),
    .cnt_overflow(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // Downstream ready generator
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_ready = 1'b0;
      1:       m_ready = 1'b1;
      default: m_ready = 1'($urandom % 2);
    endcase
  end

  // Queue-manager responder: answers each req after 0..2 idle cycles, plus stray pulses on demand
  int resp_cnt = -1, last_stray = 0;
  always @(posedge clk) begin
    #1;
    qm_valid = 1'b0;
    if (!rst_n) resp_cnt = -1;
    else begin
      if (resp_cnt == 0) begin
        qm_valid = 1'b1;
        qm_desc  = resp_fix ? fix_desc : DW'($urandom);
        resp_cnt = -1;
      end else if (resp_cnt > 0) resp_cnt--;
      if (resp_en && qm_req) resp_cnt = resp_fix ? 1 : int'($urandom_range(0, 2));
    end
    if (stray_seq != last_stray) begin
      last_stray = stray_seq;
      qm_valid   = 1'b1;
      qm_desc    = stray_desc;
    end
  end

  // Reference model: pending counts, round-robin pointer, one transaction in flight
  int            m_cnt[NA];
  int            m_ptr, pend_app, cur_app, nxt_app, dec_app, eidx;
  bit            m_ovf, m_busy, m_wait, m_out, pend, nxt_pend;
  logic [DW-1:0] m_exp;
  always @(negedge clk) begin
    if (!rst_n) begin
      foreach (m_cnt[a]) m_cnt[a] = 0;
      m_ptr = 0; m_ovf = 0; m_busy = 0; m_wait = 0; m_out = 0; pend = 0; pend_app = 0; cur_app = 0;
    end else begin
      n_tests++;
      if (qm_req !== pend) begin n_fail++; $display("FAIL model_req: got %0b exp %0b", qm_req, pend); end
      if (pend) begin
        n_tests++;
        if (qm_app_id !== AW'(pend_app)) begin n_fail++; $display("FAIL model_grant: got %0d exp %0d", qm_app_id, pend_app); end
        grant_log.push_back(pend_app);
      end else if (m_busy) begin
        n_tests++;
        if (qm_app_id !== AW'(cur_app)) begin n_fail++; $display("FAIL model_app_hold: got %0d exp %0d", qm_app_id, cur_app); end
      end
      n_tests++;
      if (m_valid !== m_out) begin n_fail++; $display("FAIL model_mvalid: got %0b exp %0b", m_valid, m_out); end
      if (m_out) begin
        n_tests++;
        if (m_desc !== m_exp) begin n_fail++; $display("FAIL model_mdesc: got %0h exp %0h", m_desc, m_exp); end
      end
      n_tests++;
      if (ovf !== m_ovf) begin n_fail++; $display("FAIL model_ovf: got %0b exp %0b", ovf, m_ovf); end

      dec_app = -1; nxt_pend = 0; nxt_app = 0;
      if (pend) begin
        m_busy = 1; cur_app = pend_app; dec_app = pend_app; m_ptr = (pend_app + 1) % NA;
      end else if (!m_busy) begin
        for (int i = 0; i < NA; i++) begin
          eidx = (m_ptr + i) % NA;
          if (!nxt_pend && m_cnt[eidx] > 0 && s_app_mask[eidx]) begin nxt_pend = 1; nxt_app = eidx; end
        end
      end else if (m_wait && qm_valid) begin
        m_out = 1; m_exp = qm_desc; m_wait = 0;
      end else if (m_out && m_ready) begin
        m_out = 0; m_busy = 0;
      end
      if (pend) m_wait = 1;
      pend = nxt_pend; pend_app = nxt_app;
      if (dec_app >= 0) m_cnt[dec_app]--;
      if (s_evt_valid) begin
        if (m_cnt[s_evt_app_id] == CMAX) m_ovf = 1;
        else m_cnt[s_evt_app_id]++;
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; s_evt_valid = 1'b0; s_app_mask = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send_evt(input int app);
    @(posedge clk); #1;
    s_evt_valid = 1'b1; s_evt_app_id = AW'(app);
  endtask

  task automatic evt_idle();
    @(posedge clk); #1 s_evt_valid = 1'b0;
  endtask

  task automatic set_mask(input logic [NA-1:0] m);
    @(posedge clk); #1 s_app_mask = m;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; #1;
    n_tests++; if (qm_req !== 1'b0)   begin n_fail++; $display("FAIL reset_req: got %0b exp 0", qm_req); end
    n_tests++; if (qm_app_id !== '0)  begin n_fail++; $display("FAIL reset_app: got %0d exp 0", qm_app_id); end
    n_tests++; if (m_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_mvalid: got %0b exp 0", m_valid); end
    n_tests++; if (m_desc !== '0)     begin n_fail++; $display("FAIL reset_mdesc: got %0h exp 0", m_desc); end
    n_tests++; if (ovf !== 1'b0)      begin n_fail++; $display("FAIL reset_ovf: got %0b exp 0", ovf); end
    n_tests++; if (s_evt_ready !== 1'b1) begin n_fail++; $display("FAIL evt_ready: got %0b exp 1", s_evt_ready); end
    do_reset();
  endtask

  task automatic test_single();
    int base;
    do_reset();
    resp_fix = 1'b1; fix_desc = 16'hABCD; rdy_mode = 1;
    set_mask(4'hF);
    base = grant_log.size();
    send_evt(2);
    evt_idle();
    n_tests++; if (qm_req !== 1'b0) begin n_fail++; $display("FAIL single_early_req: got %0b exp 0", qm_req); end
    @(posedge clk); #1;
    n_tests++; if (qm_req !== 1'b1) begin n_fail++; $display("FAIL single_req: got %0b exp 1", qm_req); end
    n_tests++; if (qm_app_id !== 2'd2) begin n_fail++; $display("FAIL single_app: got %0d exp 2", qm_app_id); end
    repeat (2) @(posedge clk); #1;
    n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL single_mvalid_early: got %0b exp 0", m_valid); end
    @(posedge clk); #1;
    n_tests++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL single_mvalid: got %0b exp 1", m_valid); end
    n_tests++; if (m_desc !== 16'hABCD) begin n_fail++; $display("FAIL single_desc: got %0h exp abcd", m_desc); end
    @(posedge clk); #1;
    n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL single_mvalid_drop: got %0b exp 0", m_valid); end
    repeat (10) @(posedge clk); #1;
    n_tests++; if (grant_log.size() - base !== 1) begin n_fail++; $display("FAIL single_count: got %0d grants exp 1", grant_log.size() - base); end
    resp_fix = 1'b0;
  endtask

  task automatic test_round_robin();
    int apps[9], exp_ord[3], base, t, j;
    exp_ord = '{0, 1, 3};
    do_reset();
    rdy_mode = 1;
    for (int i = 0; i < 9; i++) apps[i] = exp_ord[i % 3];
    for (int i = 8; i > 0; i--) begin
      j = int'($urandom_range(0, i)); t = apps[i]; apps[i] = apps[j]; apps[j] = t;
    end
    foreach (apps[i]) send_evt(apps[i]);
    evt_idle();
    base = grant_log.size();
    set_mask(4'hF);
    for (int c = 0; c < 300 && grant_log.size() < base + 9; c++) @(posedge clk);
    n_tests++;
    if (grant_log.size() < base + 9) begin n_fail++; $display("FAIL rr_timeout: got %0d grants exp 9", grant_log.size() - base); end
    else for (int i = 0; i < 9; i++) begin
      n_tests++;
      if (grant_log[base + i] !== exp_ord[i % 3]) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d exp %0d", i, grant_log[base + i], exp_ord[i % 3]); end
    end
  endtask

  task automatic test_mask();
    int base;
    do_reset();
    rdy_mode = 1;
    set_mask(4'b1101);
    send_evt(1); send_evt(1);
    evt_idle();
    base = grant_log.size();
    repeat (5) @(posedge clk);
    stray_desc = 16'h5A5A; stray_seq++;
    repeat (15) @(posedge clk); #1;
    n_tests++; if (grant_log.size() !== base) begin n_fail++; $display("FAIL mask_blocked: got %0d grants exp 0", grant_log.size() - base); end
    set_mask(4'b1111);
    @(posedge clk); #1;
    n_tests++; if (qm_req !== 1'b1) begin n_fail++; $display("FAIL mask_req: got %0b exp 1", qm_req); end
    n_tests++; if (qm_app_id !== 2'd1) begin n_fail++; $display("FAIL mask_app: got %0d exp 1", qm_app_id); end
    for (int c = 0; c < 50 && grant_log.size() < base + 2; c++) @(posedge clk);
    n_tests++; if (grant_log.size() !== base + 2) begin n_fail++; $display("FAIL mask_drain: got %0d grants exp 2", grant_log.size() - base); end
  endtask

  task automatic test_saturation();
    int base;
    do_reset();
    rdy_mode = 2;
    for (int i = 0; i < 255; i++) send_evt(0);
    evt_idle();
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL sat_ovf_early: got %0b exp 0", ovf); end
    send_evt(0);
    evt_idle();
    n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL sat_ovf: got %0b exp 1", ovf); end
    base = grant_log.size();
    set_mask(4'b0001);
    for (int c = 0; c < 5000 && grant_log.size() < base + 255; c++) @(posedge clk);
    repeat (30) @(posedge clk); #1;
    n_tests++; if (grant_log.size() - base !== 255) begin n_fail++; $display("FAIL sat_grants: got %0d exp 255", grant_log.size() - base); end
    n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL sat_ovf_sticky: got %0b exp 1", ovf); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d;
    int base, c;
    do_reset();
    rdy_mode = 0;
    set_mask(4'b1000);
    for (int i = 0; i < 256; i++) send_evt(2);
    send_evt(3); send_evt(3);
    evt_idle();
    for (c = 0; c < 50 && !m_valid; c++) begin @(posedge clk); #1; end
    n_tests++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL bp_timeout: got mvalid %0b exp 1", m_valid); end
    d = m_desc; base = grant_log.size();
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin stray_desc = ~d; stray_seq++; end
      @(posedge clk); #1;
      n_tests++;
      if (m_valid !== 1'b1 || m_desc !== d || qm_req !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got v=%0b d=%0h req=%0b exp v=1 d=%0h req=0", i, m_valid, m_desc, qm_req, d);
      end
    end
    resp_en = 1'b0; rdy_mode = 1;
    for (c = 0; c < 20 && !qm_req; c++) begin @(posedge clk); #1; end
    n_tests++; if (qm_app_id !== 2'd3 || qm_req !== 1'b1) begin n_fail++; $display("FAIL bp_second_req: got req=%0b app=%0d exp req=1 app=3", qm_req, qm_app_id); end
    n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL bp_ovf_pre: got %0b exp 1", ovf); end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_tests++;
    if (qm_req !== 1'b0 || qm_app_id !== '0 || m_valid !== 1'b0 || m_desc !== '0 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL bp_async_reset: got req=%0b app=%0d v=%0b d=%0h ovf=%0b exp all 0", qm_req, qm_app_id, m_valid, m_desc, ovf);
    end
    @(posedge clk); #1 rst_n = 1'b1; resp_en = 1'b1;
    base = grant_log.size();
    repeat (10) @(posedge clk); #1;
    n_tests++; if (grant_log.size() !== base) begin n_fail++; $display("FAIL bp_post_reset: got %0d grants exp 0", grant_log.size() - base); end
  endtask

  task automatic test_random();
    int quiet;
    do_reset();
    rdy_mode = 2; resp_en = 1'b1;
    s_app_mask = 4'hF;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      s_evt_valid  = ($urandom % 4 == 0);
      s_evt_app_id = AW'($urandom);
      if ($urandom % 50 == 0) s_app_mask = NA'($urandom);
    end
    evt_idle();
    s_app_mask = 4'hF;
    quiet = 0;
    for (int c = 0; c < 6000 && quiet < 20; c++) begin
      @(posedge clk); #1;
      quiet = (qm_req || m_valid) ? 0 : quiet + 1;
    end
    n_tests++; if (quiet < 20) begin n_fail++; $display("FAIL random_drain: got %0d quiet cycles exp 20", quiet); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_mask();
    test_saturation();
    test_backpressure();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
